// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   loader_state_t : loader FSM states
//   HDR_BYTES      : length-header size in bytes (little-endian word count)
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   WORD_W         : instruction word width in bits
package inst_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StDone
  } loader_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte packer: each push shifts a byte in from the top, so after
// four pushes the first byte sits in bits [7:0].
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : empty the packer (priority over push_i)
//   push_i        : shift byte_i in
//   byte_i        : stream byte
//   word_o        : packed word (complete after the fourth push)
//   full_o        : three bytes held; the next push completes the word
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    count_d = count_q;
    word_d  = word_q;
    if (clear_i) begin
      count_d = '0;
      word_d  = '0;
    end else if (push_i) begin
      word_d  = {byte_i, word_q[WORD_W-1:8]};
      count_d = count_q + 2'd1;  // wraps to 0 on the fourth byte
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      word_q  <= '0;
    end else begin
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  assign word_o = word_q;
  assign full_o = (count_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory writer. Takes a byte stream (2-byte word count N,
// then 4*N little-endian instruction bytes) and writes each word to consecutive
// word addresses from 0, holding the CPU off until the load completes cleanly.
//   clk_i, rst_ni         : clock, async active-low reset
//   start_i               : begin a load (honoured in idle/done only)
//   in_valid_i, in_data_i : byte stream input
//   in_ready_o            : a byte can be accepted this cycle
//   wr_en_o               : one-cycle write strobe
//   wr_adr_o, wr_data_o   : byte address (word aligned) and instruction word
//   cpu_hold_o            : high until a load completes without error
//   done_o, err_o         : load finished / length exceeded depth (levels)
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  output logic        wr_en_o,
  output logic [31:0] wr_adr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  // One extra bit so N == 2^ADDR_W reaches its last index without wrapping.
  localparam int unsigned IdxW = ADDR_W + 1;

  loader_state_t     state_q;
  logic [15:0]       n_q;
  logic [IdxW-1:0]   idx_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [31:0]       wr_adr_q;
  logic [31:0]       wr_data_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;

  logic              xfer;
  logic [15:0]       len_full;
  logic              len_too_big;
  logic              last_word;
  logic              pk_clear;
  logic              pk_push;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;

  assign xfer        = in_valid_i && in_ready_q;
  assign len_full    = {in_data_i, n_q[7:0]};
  assign len_too_big = ({16'd0, len_full} > (32'd1 << ADDR_W));
  assign last_word   = (32'(idx_q) == (32'(n_q) - 32'd1));
  assign pk_clear    = (state_q == StLenHi) && xfer;
  assign pk_push     = (state_q == StData) && xfer;

  byte_packer u_packer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (pk_clear),
    .push_i  (pk_push),
    .byte_i  (in_data_i),
    .word_o  (pk_word),
    .full_o  (pk_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      n_q        <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StLenLo;
            in_ready_q <= 1'b1;
          end
        end
        StLenLo: begin
          if (xfer) begin
            n_q[7:0] <= in_data_i;
            state_q  <= StLenHi;
          end
        end
        StLenHi: begin
          if (xfer) begin
            n_q[15:8] <= in_data_i;
            if (len_full == 16'd0) begin
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else if (len_too_big) begin
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              state_q <= StData;
              idx_q   <= '0;
            end
          end
        end
        StData: begin
          if (xfer && pk_full) begin
            state_q    <= StWrite;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            wr_adr_q   <= 32'(idx_q[ADDR_W-1:0]) << 2;
          end
        end
        StWrite: begin
          wr_data_q <= pk_word;
          idx_q     <= idx_q + IdxW'(1);
          if (last_word) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= StData;
            in_ready_q <= 1'b1;
          end
        end
        StDone: begin
          if (start_i) begin
            state_q    <= StLenLo;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_adr_o   = wr_adr_q;
  // The packer holds the finished word through the write cycle; the copy
  // keeps wr_data stable once new bytes start shifting in.
  assign wr_data_o  = wr_en_q ? pk_word : wr_data_q;
  assign cpu_hold_o = cpu_hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  typedef logic [7:0] byteq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drv_start = 1'b0;
  logic        drv_valid = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  logic        sel4 = 1'b0;

  logic        start16, valid16, start4, valid4;
  logic        in_ready16, wr_en16, hold16, done16, err16;
  logic [31:0] wr_adr16, wr_data16;
  logic        in_ready4, wr_en4, hold4, done4, err4;
  logic [31:0] wr_adr4, wr_data4;

  assign start16 = drv_start & ~sel4;
  assign valid16 = drv_valid & ~sel4;
  assign start4  = drv_start & sel4;
  assign valid4  = drv_valid & sel4;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .in_valid_i(valid16),
    .in_ready_o(in_ready16), .in_data_i(drv_data), .wr_en_o(wr_en16),
    .wr_adr_o(wr_adr16), .wr_data_o(wr_data16), .cpu_hold_o(hold16),
    .done_o(done16), .err_o(err16)
  );

  inst_mem_loader #(.ADDR_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .in_valid_i(valid4),
    .in_ready_o(in_ready4), .in_data_i(drv_data), .wr_en_o(wr_en4),
    .wr_adr_o(wr_adr4), .wr_data_o(wr_data4), .cpu_hold_o(hold4),
    .done_o(done4), .err_o(err4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the 16-bit-address loader: header bytes build N,
  // data bytes are placed by position into the word, a write follows each word.
  localparam int unsigned AW = 16;
  bit          m_active, m_ready, m_wr, m_done, m_err, m_hold;
  int unsigned m_hdr, m_n, m_got, m_widx;
  logic [31:0] m_adr, m_data, m_word;

  task automatic model_reset();
    m_active = 0; m_ready = 0; m_wr = 0; m_done = 0; m_err = 0; m_hold = 1;
    m_hdr = 0; m_n = 0; m_got = 0; m_widx = 0;
    m_adr = '0; m_data = '0; m_word = '0;
  endtask

  task automatic model_finish(input bit e);
    m_active = 0; m_done = 1; m_err = e; m_hold = e;
  endtask

  task automatic model_step(input bit st, input bit v, input logic [7:0] d);
    bit xfer;
    bit wr_next;
    xfer = v && m_ready;
    wr_next = 0;
    if (m_wr) begin
      m_widx++;
      if (m_widx == m_n) model_finish(0);
    end else if (m_active && xfer) begin
      if (m_hdr < 2) begin
        m_n = m_n | (int'(d) << (8 * m_hdr));
        m_hdr++;
        if (m_hdr == 2) begin
          if (m_n == 0) model_finish(0);
          else if (m_n > (1 << AW)) model_finish(1);
          else begin m_got = 0; m_widx = 0; end
        end
      end else begin
        m_word[8*m_got +: 8] = d;
        m_got++;
        if (m_got == 4) begin
          wr_next = 1;
          m_adr = 32'(m_widx * 4);
          m_data = m_word;
          m_got = 0;
        end
      end
    end else if (!m_active && st) begin
      m_active = 1; m_hdr = 0; m_n = 0; m_done = 0; m_err = 0; m_hold = 1;
    end
    m_wr = wr_next;
    m_ready = m_active && !wr_next;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(start16, valid16, drv_data);
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready", {31'd0, in_ready16}, {31'd0, m_ready});
        check("wr_en", {31'd0, wr_en16}, {31'd0, m_wr});
        check("wr_adr", wr_adr16, m_adr);
        check("wr_data", wr_data16, m_data);
        check("done", {31'd0, done16}, {31'd0, m_done});
        check("cpu_hold", {31'd0, hold16}, {31'd0, m_hold});
        check("err", {31'd0, err16}, {31'd0, m_err});
      end
    end
  end

  // Write logs and activity counters used by the directed checks.
  logic [31:0] wlog_adr[$];
  logic [31:0] wlog_dat[$];
  int          act_cyc = 0;
  int          rdy_in_wr = 0;
  int          w4_cnt = 0;
  logic [31:0] w4_adr = '0;
  logic [31:0] w4_dat = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en16) begin
          wlog_adr.push_back(wr_adr16);
          wlog_dat.push_back(wr_data16);
        end
        if (in_ready16 || wr_en16) act_cyc++;
        if (in_ready16 && wr_en16) rdy_in_wr++;
        if (wr_en4) begin
          w4_cnt++;
          w4_adr = wr_adr4;
          w4_dat = wr_data4;
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge after the last byte transferred.
  task automatic stream(input byteq_t bytes, input bit gaps, input int start_at);
    int i;
    int cyc;
    bit rdy;
    i = 0;
    cyc = 0;
    while (i < bytes.size() && cyc < 4000) begin
      drv_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_data  = bytes[i];
      drv_start = (start_at >= 0 && i == start_at);
      rdy = sel4 ? in_ready4 : in_ready16;
      @(posedge clk);
      if (drv_valid && rdy) i++;
      cyc++;
      @(negedge clk);
    end
    drv_valid = 1'b0;
    drv_start = 1'b0;
    check("stream_complete", 32'(i), 32'(bytes.size()));
  endtask

  task automatic pulse_start();
    drv_start = 1'b1;
    @(negedge clk);
    drv_start = 1'b0;
  endtask

  task automatic wait_done16(input int bound);
    int c;
    c = 0;
    while (!done16 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("done_within_bound", {31'd0, done16}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  byteq_t      q;
  logic [31:0] ref_adr[$];
  logic [31:0] ref_dat[$];

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_in_ready", {31'd0, in_ready16}, 32'd0);
    check("rst_cpu_hold", {31'd0, hold16}, 32'd1);
    check("rst_done", {31'd0, done16}, 32'd0);
    check("rst_wr_adr", wr_adr16, 32'd0);

    // N=1
    pulse_start();
    q = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h08, 8'h20};
    stream(q, 1'b0, -1);
    check("n1_wr_en", {31'd0, wr_en16}, 32'd1);
    check("n1_wr_adr", wr_adr16, 32'h0);
    check("n1_wr_data", wr_data16, 32'h20080020);
    @(negedge clk);
    check("n1_done", {31'd0, done16}, 32'd1);
    check("n1_cpu_hold", {31'd0, hold16}, 32'd0);
    check("n1_nwrites", 32'(wlog_adr.size()), 32'd1);

    // N=3 back-to-back
    wlog_adr.delete(); wlog_dat.delete();
    act_cyc = 0; rdy_in_wr = 0;
    pulse_start();
    q = '{8'h03, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
          8'h33, 8'h33, 8'h33, 8'h33};
    stream(q, 1'b0, -1);
    wait_done16(10);
    check("n3_nwrites", 32'(wlog_adr.size()), 32'd3);
    if (wlog_adr.size() == 3) begin
      check("n3_adr0", wlog_adr[0], 32'h0);
      check("n3_adr1", wlog_adr[1], 32'h4);
      check("n3_adr2", wlog_adr[2], 32'h8);
      check("n3_dat2", wlog_dat[2], 32'h33333333);
    end
    check("n3_active_cycles", 32'(act_cyc), 32'd17);  // 2 header + 15 data/write
    check("n3_ready_in_write", 32'(rdy_in_wr), 32'd0);

    // N=0
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    q = '{8'h00, 8'h00};
    stream(q, 1'b0, -1);
    check("n0_done", {31'd0, done16}, 32'd1);
    check("n0_cpu_hold", {31'd0, hold16}, 32'd0);
    repeat (2) @(negedge clk);
    check("n0_nwrites", 32'(wlog_adr.size()), 32'd0);

    // N=2 gap-free reference, then with gaps and a mid-DATA start
    q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hD8, 8'hC7, 8'hB6, 8'hA5};
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    stream(q, 1'b0, -1);
    wait_done16(10);
    ref_adr = wlog_adr;
    ref_dat = wlog_dat;
    if (ref_dat.size() == 2) begin
      check("n2_dat0", ref_dat[0], 32'h04030201);
      check("n2_dat1", ref_dat[1], 32'hA5B6C7D8);
    end
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    stream(q, 1'b1, 4);
    wait_done16(20);
    check("gap_nwrites", 32'(wlog_adr.size()), 32'(ref_adr.size()));
    if (wlog_adr.size() == ref_adr.size()) begin
      foreach (ref_adr[k]) begin
        check("gap_adr", wlog_adr[k], ref_adr[k]);
        check("gap_dat", wlog_dat[k], ref_dat[k]);
      end
    end

    // Reset after 6 data bytes of N=2
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hD8, 8'hC7};
    stream(q, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready16}, 32'd0);
    check("arst_wr_en", {31'd0, wr_en16}, 32'd0);
    check("arst_wr_adr", wr_adr16, 32'd0);
    check("arst_wr_data", wr_data16, 32'd0);
    check("arst_cpu_hold", {31'd0, hold16}, 32'd1);
    check("arst_done", {31'd0, done16}, 32'd0);
    check("arst_nwrites", 32'(wlog_adr.size()), 32'd1);
    if (wlog_adr.size() >= 1) check("arst_adr0", wlog_adr[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    stream(q, 1'b0, -1);
    wait_done16(10);
    check("fresh_hold", {31'd0, hold16}, 32'd0);
    if (wlog_dat.size() == 1) check("fresh_dat", wlog_dat[0], 32'hDEADBEEF);
    else check("fresh_nwrites", 32'(wlog_dat.size()), 32'd1);

    // ADDR_W=4: N=17 errors, N=16 loads fully
    sel4 = 1'b1;
    pulse_start();
    q = '{8'h11, 8'h00};
    stream(q, 1'b0, -1);
    check("w4_err", {31'd0, err4}, 32'd1);
    check("w4_done", {31'd0, done4}, 32'd1);
    check("w4_hold", {31'd0, hold4}, 32'd1);
    check("w4_nowrites", 32'(w4_cnt), 32'd0);
    pulse_start();
    check("w4_err_cleared", {31'd0, err4}, 32'd0);
    check("w4_done_cleared", {31'd0, done4}, 32'd0);
    check("w4_ready", {31'd0, in_ready4}, 32'd1);
    q = '{8'h10, 8'h00};
    for (int i = 0; i < 64; i++) q.push_back(8'(i));
    stream(q, 1'b0, -1);
    repeat (2) @(negedge clk);
    check("w4_nwrites", 32'(w4_cnt), 32'd16);
    check("w4_last_adr", w4_adr, 32'h3C);
    check("w4_last_dat", w4_dat, 32'h3F3E3D3C);
    check("w4_full_err", {31'd0, err4}, 32'd0);
    check("w4_full_hold", {31'd0, hold4}, 32'd0);
    sel4 = 1'b0;

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Boot-time writer for the single-cycle MIPS instruction memory. It accepts a byte stream over a valid/ready handshake and packs every four bytes into a little-endian 32-bit instruction. It writes each word to consecutive word addresses starting at 0 and holds the CPU off (`cpu_hold`) until the whole program is in memory. It is the write-side counterpart of the instruction memory's read port: same word-aligned byte addressing (`adr[31:2]` selects the word).

## Interface
- `ADDR_W`, 16: word-address width; memory depth is 2^ADDR_W words.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; honoured only in IDLE or DONE.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_ready`  out  1  block can accept a byte this cycle.
- `in_data`  in  8  stream byte.
- `wr_en`  out  1  one-cycle write strobe to instruction memory.
- `wr_adr`  out  32  byte address, bits [1:0] always 0, bits [31:ADDR_W+2] always 0.
- `wr_data`  out  32  instruction word.
- `cpu_hold`  out  1  high until a load completes without error.
- `done`  out  1  load finished; level, held until next `start`.
- `err`  out  1  header length exceeded depth; level, held until next `start`.

## Operation
- Stream format: 2-byte word count N (low byte first), then 4·N data bytes, each word little-endian (first byte → bits [7:0]).
- A byte transfers on a rising edge with `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready`=0; on `start` → LEN_LO.
  - LEN_LO: `in_ready`=1; on transfer, latch N[7:0] → LEN_HI.
  - LEN_HI: `in_ready`=1; on transfer, latch N[15:8], then:
    - N==0 → DONE.
    - N > 2^ADDR_W → DONE with `err`=1.
    - otherwise → DATA, with byte counter=0 and word index=0.
  - DATA: `in_ready`=1; on transfer, shift the byte into the packer and increment the byte counter (2 bits). On the 4th byte → WRITE.
  - WRITE: `in_ready`=0, `wr_en`=1, `wr_adr`={word index,2'b00}, `wr_data`=packed word. Then increment the word index: if the index was N−1 → DONE, else → DATA.
  - DONE: `in_ready`=0, `done`=1, `cpu_hold`=`err`. On `start`, clear `done` and `err`, set `cpu_hold`=1 → LEN_LO.
- `start` in LEN_LO, LEN_HI, DATA or WRITE is ignored.
- `in_valid` outside the accepting states is ignored; no byte is consumed.
- Width rules:
  - The word index counter is ADDR_W+1 bits, so N=2^ADDR_W terminates with no wrap.
  - The length compare is done on the full 16-bit N; with ADDR_W=16 it can never error.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_adr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `err`=0, counters 0.
- Reset asserted mid-load aborts immediately:
  - The partial word is discarded.
  - Words already written stay in memory; the memory itself is not reset.
- `wr_en` is registered and high for exactly one cycle per word, in the cycle after the 4th byte is accepted.
- Peak throughput is 4 bytes per 5 cycles.
- `done` rises, and `cpu_hold` falls (no error), in the cycle after the last `wr_en`.
- Back-to-back bytes are accepted every cycle in LEN_LO, LEN_HI and DATA. A stalled source (`in_valid`=0) simply holds the state.
- `wr_adr` and `wr_data` are stable while `wr_en`=1; outside the strobe they hold their last values.

## Structure
- Package `inst_loader_pkg`:
  - state enum `loader_state_t` (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE);
  - `HDR_BYTES`=2;
  - `BYTES_PER_WORD`=4.
- Sub-module `byte_packer`:
  - 4-byte little-endian shift register with a 2-bit count;
  - `clear`/`push` inputs, `word` and `full` outputs.
- Top level holds the FSM, the N register and the word index counter.

## Test plan
- Reset, then `start`, then stream 01 00 | 20 00 08 20 (N=1) → one `wr_en` pulse with `wr_adr`=0 and `wr_data`=32'h20080020. `done`=1 and `cpu_hold`=0 the next cycle.
- N=3 with words 32'h11111111, 32'h22222222, 32'h33333333, `in_valid` held high → `wr_en` at addresses 0, 4, 8. `in_ready` is low in each WRITE cycle and there are 15 transfer/write cycles after the header.
- Header 00 00 → DONE with no `wr_en`, `done`=1, `cpu_hold`=0.
- ADDR_W=4, header 11 00 (N=17) → `err`=1, `done`=1, `cpu_hold`=1, no writes. A second `start` clears `err`.
- Random `in_valid` gaps during N=2 → identical writes to the gap-free run. `start` pulsed mid-DATA has no effect.
- `rst_n` pulsed low after 6 data bytes of N=2 → outputs return to reset values asynchronously and only address 0 was written. A fresh load then completes normally.
